pipe_tx_data_lanes: RTL and testbench

- Registered, multi-lane successor to the single-lane combinational PIPE TX data mapper.
- Sits between the per-lane scramblers and the PIPE TX interface to the PHY.
- Per lane, masks data and K bits to the active generation's PIPE width.
- Tracks 128b/130b block boundaries with a beat counter to drive TxStartBlock and TxSyncHeader, and flags illegal sync headers.
- Generation changes, lane enables and an explicit flush are applied cleanly.

---
 rtl/pipe_tx_data_lanes_pkg.sv | 29 ++
 rtl/pipe_tx_data_lanes_if.sv | 26 ++
 rtl/pipe_tx_data_lanes_lane.sv | 77 +++++++
 rtl/pipe_tx_data_lanes.sv | 99 +++++++++
 tb/tb_pipe_tx_data_lanes.sv | 241 ++++++++++++++++++++++++
 5 files changed

// File: rtl/pipe_tx_data_lanes_pkg.sv
// Shared constants and helpers for the multi-lane PIPE TX data mapper.
package pipe_pkg;

   localparam logic [2:0] GEN1 = 3'd1;
   localparam logic [2:0] GEN2 = 3'd2;
   localparam logic [2:0] GEN3 = 3'd3;
   localparam logic [2:0] GEN4 = 3'd4;
   localparam logic [2:0] GEN5 = 3'd5;

   localparam int BLOCK_BITS = 128;

   localparam logic [1:0] SH_DATA = 2'b10;
   localparam logic [1:0] SH_OS   = 2'b01;

   // Zero means "no PIPE width": the generation code is idle.
   function automatic int width_of_gen(input logic [2:0] gen,
                                       input int w1, input int w2, input int w3,
                                       input int w4, input int w5);
      case (gen)
         GEN1:    return w1;
         GEN2:    return w2;
         GEN3:    return w3;
         GEN4:    return w4;
         GEN5:    return w5;
         default: return 0;
      endcase
   endfunction

endpackage

// File: rtl/pipe_tx_data_lanes_if.sv
// Scrambler-to-PIPE bus: per-lane scrambler beats in, registered PIPE TX signals out.
interface pipe_tx_data_lanes_if #(parameter int LANES = 16);

   logic [32*LANES-1:0] scramblerDataOut;
   logic [4*LANES-1:0]  scramblerDataK;
   logic [2*LANES-1:0]  scramblerSyncHeader;
   logic                scramblerDataValid;

   logic [32*LANES-1:0] TxData;
   logic [4*LANES-1:0]  TxDataK;
   logic [LANES-1:0]    TxDataValid;
   logic [LANES-1:0]    TxStartBlock;
   logic [2*LANES-1:0]  TxSyncHeader;
   logic [LANES-1:0]    syncHdrErr;

   modport master (
      output scramblerDataOut, scramblerDataK, scramblerSyncHeader, scramblerDataValid,
      input  TxData, TxDataK, TxDataValid, TxStartBlock, TxSyncHeader, syncHdrErr
   );

   modport slave (
      input  scramblerDataOut, scramblerDataK, scramblerSyncHeader, scramblerDataValid,
      output TxData, TxDataK, TxDataValid, TxStartBlock, TxSyncHeader, syncHdrErr
   );

endinterface

// File: rtl/pipe_tx_data_lanes_lane.sv
// One PIPE TX lane: width masking, output registers and sticky sync-header error.
module pipe_tx_lane
   import pipe_pkg::*;
(
   input  logic        pclk,
   input  logic        reset_n,
   input  logic        blank,
   input  logic        clr_err,
   input  logic        en,
   input  logic        valid,
   input  logic        sob,
   input  logic [31:0] dmask,
   input  logic [3:0]  kmask,
   input  logic [31:0] din,
   input  logic [3:0]  kin,
   input  logic [1:0]  shin,
   output logic [31:0] tx_data,
   output logic [3:0]  tx_k,
   output logic        tx_vld,
   output logic        tx_sb,
   output logic [1:0]  tx_sh,
   output logic        err
);

   logic [31:0] data_p1;
   logic [3:0]  k_p1;
   logic        vld_p1;
   logic        sb_p1;
   logic [1:0]  sh_p1;
   logic        err_p1;
   logic        sh_bad;

   assign sh_bad = (shin != SH_DATA) && (shin != SH_OS);

   // p0 -> p1: lane output register
   always_ff @(posedge pclk or negedge reset_n) begin
      if (!reset_n) begin
         data_p1 <= '0;
         k_p1    <= '0;
         vld_p1  <= 1'b0;
         sb_p1   <= 1'b0;
         sh_p1   <= '0;
         err_p1  <= 1'b0;
      end else begin
         if (blank || !en) begin
            data_p1 <= '0;
            k_p1    <= '0;
            vld_p1  <= 1'b0;
            sb_p1   <= 1'b0;
            sh_p1   <= '0;
         end else if (valid) begin
            data_p1 <= din & dmask;
            k_p1    <= kin & kmask;
            vld_p1  <= 1'b1;
            sb_p1   <= sob;
            if (sob) sh_p1 <= shin;
         end else begin
            // Idle beat: data and header hold so the PHY sees a stable bus.
            vld_p1 <= 1'b0;
            sb_p1  <= 1'b0;
         end

         if (clr_err)
            err_p1 <= 1'b0;
         else if (!blank && en && valid && sob && sh_bad)
            err_p1 <= 1'b1;
      end
   end

   assign tx_data = data_p1;
   assign tx_k    = k_p1;
   assign tx_vld  = vld_p1;
   assign tx_sb   = sb_p1;
   assign tx_sh   = sh_p1;
   assign err     = err_p1;

endmodule

// File: rtl/pipe_tx_data_lanes.sv
// Multi-lane PIPE TX data mapper: registered generation, realign control and shared block counter.
module pipe_tx_data_lanes
   import pipe_pkg::*;
#(
   parameter int LANES           = 16,
   parameter int pipe_width_gen1 = 8,
   parameter int pipe_width_gen2 = 8,
   parameter int pipe_width_gen3 = 16,
   parameter int pipe_width_gen4 = 32,
   parameter int pipe_width_gen5 = 32
) (
   input  logic                 pclk,
   input  logic                 reset_n,
   input  logic [2:0]           generation,
   input  logic [LANES-1:0]     laneEnable,
   input  logic                 flush,
   pipe_tx_data_lanes_if.slave  bus
);

   logic [2:0]  genQ;
   logic [2:0]  beat_cnt;
   logic        change;
   logic        clr;
   logic        gen_ok;
   logic        blocks;
   logic        sob;
   logic        blank;
   int          w;
   logic [31:0] dmask;
   logic [3:0]  kmask;
   logic [2:0]  last_beat;

   always_comb begin
      w         = width_of_gen(genQ, pipe_width_gen1, pipe_width_gen2, pipe_width_gen3,
                               pipe_width_gen4, pipe_width_gen5);
      gen_ok    = (genQ >= GEN1) && (genQ <= GEN5);
      blocks    = (genQ >= GEN3) && (genQ <= GEN5);
      change    = (generation != genQ);
      clr       = change || flush;
      blank     = clr || !gen_ok;
      sob       = blocks && bus.scramblerDataValid && (beat_cnt == 3'd0);
      dmask     = (w >= 32) ? 32'hFFFF_FFFF : 32'((64'd1 << w) - 64'd1);
      kmask     = 4'((8'd1 << (w / 8)) - 8'd1);
      last_beat = (w != 0) ? 3'((BLOCK_BITS / w) - 1) : 3'd0;
   end

   // p0: generation register and 128b/130b beat counter
   always_ff @(posedge pclk or negedge reset_n) begin
      if (!reset_n) begin
         genQ     <= '0;
         beat_cnt <= '0;
      end else if (clr) begin
         if (change) genQ <= generation;
         beat_cnt <= '0;
      end else if (!blocks) begin
         beat_cnt <= '0;
      end else if (bus.scramblerDataValid) begin
         beat_cnt <= (beat_cnt == last_beat) ? 3'd0 : beat_cnt + 3'd1;
      end
   end

   logic [32*LANES-1:0] tx_data;
   logic [4*LANES-1:0]  tx_k;
   logic [LANES-1:0]    tx_vld;
   logic [LANES-1:0]    tx_sb;
   logic [2*LANES-1:0]  tx_sh;
   logic [LANES-1:0]    tx_err;

   for (genvar i = 0; i < LANES; i++) begin : g_lane
      pipe_tx_lane u_lane (
         .pclk    (pclk),
         .reset_n (reset_n),
         .blank   (blank),
         .clr_err (change),
         .en      (laneEnable[i]),
         .valid   (bus.scramblerDataValid),
         .sob     (sob),
         .dmask   (dmask),
         .kmask   (kmask),
         .din     (bus.scramblerDataOut[32*i +: 32]),
         .kin     (bus.scramblerDataK[4*i +: 4]),
         .shin    (bus.scramblerSyncHeader[2*i +: 2]),
         .tx_data (tx_data[32*i +: 32]),
         .tx_k    (tx_k[4*i +: 4]),
         .tx_vld  (tx_vld[i]),
         .tx_sb   (tx_sb[i]),
         .tx_sh   (tx_sh[2*i +: 2]),
         .err     (tx_err[i])
      );
   end

   assign bus.TxData       = tx_data;
   assign bus.TxDataK      = tx_k;
   assign bus.TxDataValid  = tx_vld;
   assign bus.TxStartBlock = tx_sb;
   assign bus.TxSyncHeader = tx_sh;
   assign bus.syncHdrErr   = tx_err;

endmodule

// File: tb/tb_pipe_tx_data_lanes.sv
// Directed and randomized bench for pipe_tx_data_lanes against a beat-counting reference model.
module tb_pipe_tx_data_lanes;
   import pipe_pkg::*;

   localparam int LANES = 16;

   logic             pclk = 1'b0;
   logic             reset_n = 1'b0;
   logic [2:0]       generation = 3'd0;
   logic [LANES-1:0] laneEnable = '1;
   logic             flush = 1'b0;

   int n_assert = 0;
   int n_fail   = 0;
   int cyc      = 0;

   pipe_tx_data_lanes_if #(.LANES(LANES)) bus ();

   pipe_tx_data_lanes #(.LANES(LANES)) dut (
      .pclk       (pclk),
      .reset_n    (reset_n),
      .generation (generation),
      .laneEnable (laneEnable),
      .flush      (flush),
      .bus        (bus)
   );

   always #5 pclk = ~pclk;

   // Reference model state: generation seen by the mapper and valid beats since realign.
   int                  m_gen;
   int                  m_beats;
   logic [32*LANES-1:0] e_data;
   logic [4*LANES-1:0]  e_k;
   logic [LANES-1:0]    e_vld;
   logic [LANES-1:0]    e_sb;
   logic [2*LANES-1:0]  e_sh;
   logic [LANES-1:0]    e_err;

   logic [2*LANES-1:0]  sh_word;
   bit                  rand_sh;

   function automatic int tb_width(input int g);
      case (g)
         1: return 8;
         2: return 8;
         3: return 16;
         4: return 32;
         5: return 32;
         default: return 0;
      endcase
   endfunction

   task automatic model_reset();
      m_gen = 0; m_beats = 0;
      e_data = '0; e_k = '0; e_vld = '0; e_sb = '0; e_sh = '0; e_err = '0;
   endtask

   task automatic model_update();
      bit chg, clr, ok, blk, sob;
      int w, bpb;
      logic [1:0] sh;
      chg = (int'(generation) != m_gen);
      clr = chg || flush;
      w   = tb_width(m_gen);
      ok  = (w != 0);
      blk = (m_gen >= 3) && (m_gen <= 5);
      bpb = blk ? 128 / w : 1;
      sob = blk && (m_beats % bpb == 0);
      for (int i = 0; i < LANES; i++) begin
         sh = bus.scramblerSyncHeader[2*i +: 2];
         if (clr || !ok || !laneEnable[i]) begin
            e_data[32*i +: 32] = '0; e_k[4*i +: 4] = '0;
            e_vld[i] = 1'b0; e_sb[i] = 1'b0; e_sh[2*i +: 2] = '0;
         end else if (bus.scramblerDataValid) begin
            e_data[32*i +: 32] = 32'(64'(bus.scramblerDataOut[32*i +: 32]) % (64'd1 << w));
            e_k[4*i +: 4]      = 4'(32'(bus.scramblerDataK[4*i +: 4]) % (32'd1 << (w / 8)));
            e_vld[i] = 1'b1;
            e_sb[i]  = sob;
            if (sob) begin
               e_sh[2*i +: 2] = sh;
               if (sh == 2'b00 || sh == 2'b11) e_err[i] = 1'b1;
            end
         end else begin
            e_vld[i] = 1'b0; e_sb[i] = 1'b0;
         end
      end
      if (chg) e_err = '0;
      if (clr) begin
         m_beats = 0;
         if (chg) m_gen = int'(generation);
      end else if (!blk) begin
         m_beats = 0;
      end else if (bus.scramblerDataValid) begin
         m_beats++;
      end
   endtask

   task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s cycle %0d observed=%0h expected=%0h", tag, cyc, obs, exp);
      end
   endtask

   task automatic check_outputs();
      chk("TxData",       bus.TxData,       e_data);
      chk("TxDataK",      bus.TxDataK,      e_k);
      chk("TxDataValid",  bus.TxDataValid,  e_vld);
      chk("TxStartBlock", bus.TxStartBlock, e_sb);
      chk("TxSyncHeader", bus.TxSyncHeader, e_sh);
      chk("syncHdrErr",   bus.syncHdrErr,   e_err);
   endtask

   // Called at a falling edge: drive a beat, let the DUT register it, then compare.
   task automatic step(input logic v, input bit rnd = 1'b1);
      bus.scramblerDataValid = v;
      if (rnd) begin
         for (int i = 0; i < LANES; i++) begin
            bus.scramblerDataOut[32*i +: 32] = $urandom();
            bus.scramblerDataK[4*i +: 4]     = 4'($urandom());
         end
      end
      if (rand_sh) begin
         for (int i = 0; i < LANES; i++) bus.scramblerSyncHeader[2*i +: 2] = 2'($urandom());
      end else begin
         bus.scramblerSyncHeader = sh_word;
      end
      @(posedge pclk);
      model_update();
      cyc++;
      @(negedge pclk);
      check_outputs();
   endtask

   logic [15:0] pat16;
   logic [5:0]  pat6;
   logic [5:0]  vseq;

   initial begin
      bus.scramblerDataOut    = '0;
      bus.scramblerDataK      = '0;
      bus.scramblerSyncHeader = '0;
      bus.scramblerDataValid  = 1'b0;
      sh_word = {LANES{SH_DATA}};
      rand_sh = 1'b0;
      model_reset();

      repeat (2) @(negedge pclk);
      check_outputs();
      reset_n = 1'b1;

      // Gen1 masking to 8 bits
      generation = 3'd1;
      step(1'b1);
      bus.scramblerDataOut[31:0] = 32'hA5A5_A53C;
      bus.scramblerDataK[3:0]    = 4'b1111;
      step(1'b1, 1'b0);
      chk("gen1_data_lane0", bus.TxData[31:0], 32'h0000_003C);
      chk("gen1_k_lane0",    bus.TxDataK[3:0], 4'b0001);
      chk("gen1_sob",        bus.TxStartBlock, 16'h0);
      chk("gen1_sh",         bus.TxSyncHeader, 32'h0);
      for (int k = 0; k < 6; k++) step(1'($urandom_range(0, 1)));
      generation = 3'd2;
      for (int k = 0; k < 6; k++) step(1'($urandom_range(0, 1)));

      // Gen3: 16 continuous beats, block starts every 8
      generation = 3'd3;
      step(1'b0);
      for (int k = 0; k < 16; k++) begin
         step(1'b1);
         pat16[k] = bus.TxStartBlock[0];
      end
      chk("gen3_sob_pattern", pat16, 16'h0101);
      chk("gen3_sh_lane0",    bus.TxSyncHeader[1:0], SH_DATA);

      // Gen4 with gaps in valid
      generation = 3'd4;
      step(1'b0);
      vseq = 6'b111101;
      for (int k = 0; k < 6; k++) begin
         step(vseq[k]);
         pat6[k] = bus.TxStartBlock[0];
         chk("gen4_vld_mirror", bus.TxDataValid[0], vseq[k]);
      end
      chk("gen4_sob_pattern", pat6, 6'b100001);

      // Illegal header on lane 2, sticky through flush, cleared by Gen5 switch
      flush = 1'b1; step(1'b0); flush = 1'b0;
      sh_word[5:4] = 2'b11;
      step(1'b1);
      chk("err_lane2_set", bus.syncHdrErr, 16'h0004);
      sh_word = {LANES{SH_DATA}};
      for (int k = 0; k < 5; k++) step(1'b1);
      flush = 1'b1; step(1'b1); flush = 1'b0;
      chk("err_after_flush", bus.syncHdrErr, 16'h0004);
      chk("flush_blank_vld", bus.TxDataValid, 16'h0);
      generation = 3'd5;
      step(1'b1);
      chk("gen5_switch_vld", bus.TxDataValid, 16'h0);
      chk("gen5_switch_err", bus.syncHdrErr, 16'h0);
      chk("gen5_switch_data", bus.TxData, '0);

      // Half the lanes disabled at Gen5
      laneEnable = 16'h00FF;
      for (int k = 0; k < 6; k++) begin
         step(1'b1);
         chk("disabled_lanes_data", bus.TxData[511:256], '0);
         chk("lane_enable_vld", bus.TxDataValid, 16'h00FF);
      end

      // Randomized soak across generations, flush and enables
      rand_sh = 1'b1;
      for (int k = 0; k < 300; k++) begin
         if ($urandom_range(0, 19) == 0) generation = 3'($urandom_range(0, 7));
         flush = ($urandom_range(0, 15) == 0);
         if ($urandom_range(0, 9) == 0) laneEnable = 16'($urandom());
         step($urandom_range(0, 3) != 0);
      end

      // Reset in the middle of Gen4 traffic
      rand_sh = 1'b0; flush = 1'b0; laneEnable = '1;
      generation = 3'd4;
      for (int k = 0; k < 4; k++) step(1'b1);
      #2 reset_n = 1'b0;
      #1 model_reset();
      check_outputs();
      @(posedge pclk);
      @(negedge pclk);
      check_outputs();
      reset_n = 1'b1;
      step(1'b1);
      step(1'b1);
      chk("post_reset_sob", bus.TxStartBlock, 16'hFFFF);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
